demux_1to2: RTL and testbench
=============================

# demux_1to2

Buffered 1-to-2 demultiplexer: a single input word stream is steered, per word, to one of two output channels, each backed by a 2-entry FIFO with a valid/ready handshake. It performs the reverse of the 2-to-1 data selector used on the datapath, fanning one producer out to two consumers that may stall independently, such as a writeback bus feeding two pipeline-side sinks.

## Interface
- `size`, 32: data width in bits; legal range 1..64.
- `clk_i` input 1: clock; all state updates on the rising edge.
- `rst_i` input 1: reset, asynchronous, active-low.
- `data_i` input size: input word.
- `select_i` input 1: destination of the word; 0 → channel 0, 1 → channel 1.
- `valid_i` input 1: input word present.
- `ready_o` output 1: block accepts the word this cycle.
- `data0_o` output size: channel 0 head word.
- `valid0_o` output 1: channel 0 head valid.
- `ready0_i` input 1: channel 0 consumer takes head.
- `data1_o` output size: channel 1 head word.
- `valid1_o` output 1: channel 1 head valid.
- `ready1_i` input 1: channel 1 consumer takes head.
- `cnt0_o` output 16: channel 0 words accepted. Present only with `DEMUX_1TO2_STATS_EN`.
- `cnt1_o` output 16: channel 1 words accepted. Present only with `DEMUX_1TO2_STATS_EN`.

## Operation
- Each channel has one FIFO: depth 2, 1-bit read and write pointers, and a 2-bit occupancy count in 0..2.
- Push:
  - Push to channel k = `valid_i & ready_o & (select_i == k)`.
  - A push stores `data_i`; the select bit is not stored.
- `ready_o`:
  - Equals "the occupancy of the channel named by `select_i` is < 2".
  - It is combinational from `select_i` and the occupancy counts only.
  - It does not depend on `valid_i` or on `ready0_i`/`ready1_i`, so there is no full-FIFO pass-through.
- Pop:
  - Pop on channel k = `validk_o & readyk_i`.
  - `validk_o` = (occupancy k != 0).
  - `datak_o` = the FIFO entry at read pointer k.
  - When the channel is empty, `datak_o` holds the last popped word, or 0 if no word has been popped since reset.
- Simultaneous push and pop on one channel: occupancy is unchanged and both pointers advance.
- Pointer wrap: each pointer toggles 1→0 naturally.
- Channels are independent. A stall on one channel never blocks words addressed to the other channel.
- Illegal events:
  - Pop on an empty channel cannot occur, because valid is low.
  - Push to a full channel cannot occur, because ready is low.
  - No error flag exists.
- Reset, asserted at any time including mid-transfer:
  - All occupancy counts, pointers, FIFO storage and counters clear immediately.
  - Any buffered words are discarded.
  - `ready_o` is forced to 0 while `rst_i` is low.

## Timing
- Latency: a word accepted at edge N appears on `datak_o` with `validk_o` = 1 after edge N. This is one cycle when the FIFO was empty.
- Throughput: one word per cycle per channel is sustained while the consumer holds ready high. Occupancy stays at 1.
- Reset values:
  - `valid0_o`, `valid1_o`: 0.
  - `data0_o`, `data1_o`: 0.
  - `cnt0_o`, `cnt1_o`: 0.
  - `ready_o`: 0 during reset, 1 in the first cycle after release.
- Release of `rst_i` is synchronized by the environment. The block does not resynchronize it.
- Output data and valid come from registers and FIFO storage only. No combinational path runs from inputs to `datak_o` or `validk_o`.

## Configuration
- Macro: `DEMUX_1TO2_STATS_EN`.
- Defined:
  - `cnt0_o` and `cnt1_o` exist.
  - Each increments by 1 on every push to its channel.
  - Each saturates at 16'hFFFF and clears on reset.
- Undefined: the counters, their ports and their logic are absent. All other behaviour is identical.

## Structure
- Shared package or header holds:
  - `DEMUX_FIFO_DEPTH` = 2.
  - Pointer width = 1.
  - Occupancy width = 2.
  - Counter width = 16.
- Natural sub-module `Demux_FIFO2`:
  - Parameterized by `size`.
  - Ports: push, `data_i`, pop, `data_o`, empty, full.
  - Instantiated twice.
- The top level holds only the steering logic, `ready_o` logic and the optional counters.

## Test plan
- Reset then idle: `rst_i` = 0 then 1 → `valid0_o` = `valid1_o` = 0, both data outputs 0, `ready_o` = 1 in the first cycle after release.
- Steering: push 32'hA5A5_0001 with select 0 and 32'h5A5A_0002 with select 1 on consecutive cycles, consumers ready → each word appears one cycle after acceptance, on the correct channel only.
- Backpressure: `ready0_i` = 0, push 3 words with select 0 → first two accepted, `ready_o` = 0 on the third. A word with select 1 pushed meanwhile is accepted. Raise `ready0_i` → words drain in order, third accepted one cycle after the first pop.
- Streaming: 8 back-to-back words to channel 1, `ready1_i` held at 1 → `ready_o` stays 1 and the outputs match the input sequence with one-cycle lag.
- Mid-operation reset: 2 words buffered in each channel, assert `rst_i` asynchronously between edges → valids drop immediately, and no stale word appears after release.
- With `DEMUX_1TO2_STATS_EN`: 5 pushes to channel 0 and 3 to channel 1 → `cnt0_o` = 5, `cnt1_o` = 3. Preloaded at 16'hFFFF plus one push → stays 16'hFFFF.

Source files
------------

// File: rtl/demux_1to2_pkg.sv
// Shared constants and helpers for the buffered 1-to-2 demultiplexer.
// Optional statistics counters are enabled by DEMUX_1TO2_STATS_EN.
package demux_1to2_pkg;
   localparam int DEMUX_FIFO_DEPTH = 2;
   localparam int DEMUX_PTR_W      = 1;
   localparam int DEMUX_OCC_W      = 2;
   localparam int DEMUX_CNT_W      = 16;

   localparam logic [DEMUX_OCC_W-1:0] DEMUX_OCC_FULL = DEMUX_OCC_W'(DEMUX_FIFO_DEPTH);
   localparam logic [DEMUX_CNT_W-1:0] DEMUX_CNT_MAX  = '1;

   // Saturating increment used by the per-channel accept counters.
   function automatic logic [DEMUX_CNT_W-1:0] sat_inc(input logic [DEMUX_CNT_W-1:0] v);
      return (v == DEMUX_CNT_MAX) ? v : v + DEMUX_CNT_W'(1);
   endfunction
endpackage

// File: rtl/demux_1to2_fifo2.sv
// Two-entry FIFO for one demux output channel. When empty, the output
// shows the last word popped (0 after reset).
module Demux_FIFO2
   import demux_1to2_pkg::*;
#(
   parameter int size = 32
) (
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic            push_i,
   input  logic [size-1:0] data_i,
   input  logic            pop_i,
   output logic [size-1:0] data_o,
   output logic            empty_o,
   output logic            full_o
);
   logic [size-1:0]        mem_q [DEMUX_FIFO_DEPTH];
   logic [DEMUX_PTR_W-1:0] wr_q, rd_q;
   logic [DEMUX_OCC_W-1:0] occ_q, occ_d;
   logic [size-1:0]        last_q;

   assign empty_o = (occ_q == '0);
   assign full_o  = (occ_q == DEMUX_OCC_FULL);
   assign data_o  = empty_o ? last_q : mem_q[rd_q];

   // Occupancy next state; push and pop together leave it unchanged.
   always_comb begin
      occ_d = occ_q;
      case ({push_i, pop_i})
         2'b10:   occ_d = occ_q + DEMUX_OCC_W'(1);
         2'b01:   occ_d = occ_q - DEMUX_OCC_W'(1);
         default: occ_d = occ_q;
      endcase
   end

   // Storage, pointers and the held last-popped word.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         for (int i = 0; i < DEMUX_FIFO_DEPTH; i++) mem_q[i] <= '0;
         wr_q   <= '0;
         rd_q   <= '0;
         occ_q  <= '0;
         last_q <= '0;
      end else begin
         occ_q <= occ_d;
         if (push_i) begin
            mem_q[wr_q] <= data_i;
            wr_q        <= wr_q + DEMUX_PTR_W'(1);
         end
         if (pop_i) begin
            last_q <= mem_q[rd_q];
            rd_q   <= rd_q + DEMUX_PTR_W'(1);
         end
      end
   end
endmodule

// File: rtl/demux_1to2.sv
// Buffered 1-to-2 demultiplexer: steers each input word to one of two
// independently stalling channels. DEMUX_1TO2_STATS_EN adds saturating
// per-channel accept counters.
module demux_1to2
   import demux_1to2_pkg::*;
#(
   parameter int size = 32
) (
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic [size-1:0] data_i,
   input  logic            select_i,
   input  logic            valid_i,
   output logic            ready_o,
   output logic [size-1:0] data0_o,
   output logic            valid0_o,
   input  logic            ready0_i,
   output logic [size-1:0] data1_o,
   output logic            valid1_o,
   input  logic            ready1_i
`ifdef DEMUX_1TO2_STATS_EN
   ,
   output logic [DEMUX_CNT_W-1:0] cnt0_o,
   output logic [DEMUX_CNT_W-1:0] cnt1_o
`endif
);
   logic empty0, full0, empty1, full1;
   logic push0, push1, pop0, pop1;

   // Accept only when the addressed channel has room; held low in reset.
   assign ready_o  = rst_i & (select_i ? ~full1 : ~full0);
   assign push0    = valid_i & ready_o & ~select_i;
   assign push1    = valid_i & ready_o &  select_i;
   assign valid0_o = ~empty0;
   assign valid1_o = ~empty1;
   assign pop0     = valid0_o & ready0_i;
   assign pop1     = valid1_o & ready1_i;

   Demux_FIFO2 #(.size(size)) u_fifo0 (
      .clk_i(clk_i), .rst_i(rst_i), .push_i(push0), .data_i(data_i),
      .pop_i(pop0), .data_o(data0_o), .empty_o(empty0), .full_o(full0)
   );

   Demux_FIFO2 #(.size(size)) u_fifo1 (
      .clk_i(clk_i), .rst_i(rst_i), .push_i(push1), .data_i(data_i),
      .pop_i(pop1), .data_o(data1_o), .empty_o(empty1), .full_o(full1)
   );

`ifdef DEMUX_1TO2_STATS_EN
   logic [DEMUX_CNT_W-1:0] cnt0_q, cnt1_q;
   assign cnt0_o = cnt0_q;
   assign cnt1_o = cnt1_q;

   // Count accepted words per channel, saturating at the maximum.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         cnt0_q <= '0;
         cnt1_q <= '0;
      end else begin
         if (push0) cnt0_q <= sat_inc(cnt0_q);
         if (push1) cnt1_q <= sat_inc(cnt1_q);
      end
   end
`endif
endmodule

// File: tb/tb_demux_1to2.sv
// Directed self-checking bench for demux_1to2.
module tb_demux_1to2;
   logic        clk_i = 1'b0;
   logic        rst_i;
   logic [31:0] data_i;
   logic        select_i, valid_i, ready_o;
   logic [31:0] data0_o, data1_o;
   logic        valid0_o, valid1_o, ready0_i, ready1_i;
`ifdef DEMUX_1TO2_STATS_EN
   logic [15:0] cnt0_o, cnt1_o;
`endif
   int total = 0;
   int bad   = 0;

   always #5 clk_i = ~clk_i;

   demux_1to2 #(.size(32)) dut (
      .clk_i(clk_i), .rst_i(rst_i), .data_i(data_i), .select_i(select_i),
      .valid_i(valid_i), .ready_o(ready_o),
      .data0_o(data0_o), .valid0_o(valid0_o), .ready0_i(ready0_i),
      .data1_o(data1_o), .valid1_o(valid1_o), .ready1_i(ready1_i)
`ifdef DEMUX_1TO2_STATS_EN
      , .cnt0_o(cnt0_o), .cnt1_o(cnt1_o)
`endif
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   initial begin
      rst_i = 1'b0; data_i = '0; select_i = 1'b0; valid_i = 1'b0;
      ready0_i = 1'b0; ready1_i = 1'b0;
      #2;
      // reset state
      chk("rst_ready", ready_o, 0);
      chk("rst_v0", valid0_o, 0);
      chk("rst_v1", valid1_o, 0);
      chk("rst_d0", data0_o, 0);
      chk("rst_d1", data1_o, 0);
      @(negedge clk_i); rst_i = 1'b1; #1;
      chk("rel_ready0", ready_o, 1);
      select_i = 1'b1; #1;
      chk("rel_ready1", ready_o, 1);

      // steering
      ready0_i = 1'b1; ready1_i = 1'b1;
      valid_i = 1'b1; select_i = 1'b0; data_i = 32'hA5A5_0001;
      tick();
      chk("st_v0", valid0_o, 1);
      chk("st_d0", data0_o, 32'hA5A5_0001);
      chk("st_v1_idle", valid1_o, 0);
      select_i = 1'b1; data_i = 32'h5A5A_0002;
      tick();
      chk("st_v1", valid1_o, 1);
      chk("st_d1", data1_o, 32'h5A5A_0002);
      chk("st_v0_drained", valid0_o, 0);
      chk("st_d0_hold", data0_o, 32'hA5A5_0001);
      valid_i = 1'b0;
      tick();
      chk("st_v1_drained", valid1_o, 0);
      chk("st_d1_hold", data1_o, 32'h5A5A_0002);

      // backpressure on channel 0
      ready0_i = 1'b0;
      valid_i = 1'b1; select_i = 1'b0; data_i = 32'h11;
      #1 chk("bp_rdy1", ready_o, 1);
      tick();
      data_i = 32'h22;
      chk("bp_rdy2", ready_o, 1);
      tick();
      data_i = 32'h33;
      chk("bp_rdy3_full", ready_o, 0);
      select_i = 1'b1; data_i = 32'h44;
      #1 chk("bp_other_rdy", ready_o, 1);
      tick();
      chk("bp_v1", valid1_o, 1);
      chk("bp_d1", data1_o, 32'h44);
      chk("bp_v0", valid0_o, 1);
      chk("bp_d0_head", data0_o, 32'h11);
      select_i = 1'b0; data_i = 32'h33; ready0_i = 1'b1;
      #1 chk("bp_still_full", ready_o, 0);
      tick();
      chk("bp_pop1", data0_o, 32'h22);
      chk("bp_rdy_after_pop", ready_o, 1);
      chk("bp_v1_drained", valid1_o, 0);
      tick();
      valid_i = 1'b0;
      chk("bp_pop2", data0_o, 32'h33);
      chk("bp_v0_third", valid0_o, 1);
      tick();
      chk("bp_empty", valid0_o, 0);
      chk("bp_d0_hold", data0_o, 32'h33);

      // streaming on channel 1
      ready1_i = 1'b1; valid_i = 1'b1; select_i = 1'b1;
      for (int i = 0; i < 8; i++) begin
         data_i = 32'h100 + i;
         #1 chk("str_rdy", ready_o, 1);
         tick();
         chk("str_v1", valid1_o, 1);
         chk("str_d1", data1_o, 32'h100 + i);
      end
      valid_i = 1'b0;
      tick();
      chk("str_end", valid1_o, 0);

      // mid-operation asynchronous reset
      ready0_i = 1'b0; ready1_i = 1'b0; valid_i = 1'b1;
      select_i = 1'b0; data_i = 32'hA1; tick();
      data_i = 32'hA2; tick();
      select_i = 1'b1; data_i = 32'hB1; tick();
      data_i = 32'hB2; tick();
      valid_i = 1'b0;
      chk("mr_v0_pre", valid0_o, 1);
      chk("mr_v1_pre", valid1_o, 1);
      #2 rst_i = 1'b0;
      #1;
      chk("mr_v0", valid0_o, 0);
      chk("mr_v1", valid1_o, 0);
      chk("mr_d0", data0_o, 0);
      chk("mr_d1", data1_o, 0);
      chk("mr_ready", ready_o, 0);
      @(negedge clk_i); rst_i = 1'b1;
      ready0_i = 1'b1; ready1_i = 1'b1;
      tick();
      chk("mr_post_v0", valid0_o, 0);
      chk("mr_post_v1", valid1_o, 0);
      chk("mr_post_d0", data0_o, 0);
      chk("mr_post_d1", data1_o, 0);

`ifdef DEMUX_1TO2_STATS_EN
      chk("cnt0_rst", {16'h0, cnt0_o}, 0);
      chk("cnt1_rst", {16'h0, cnt1_o}, 0);
      valid_i = 1'b1; select_i = 1'b0;
      for (int i = 0; i < 5; i++) begin data_i = i; tick(); end
      select_i = 1'b1;
      for (int i = 0; i < 3; i++) begin data_i = i; tick(); end
      valid_i = 1'b0;
      chk("cnt0_5", {16'h0, cnt0_o}, 5);
      chk("cnt1_3", {16'h0, cnt1_o}, 3);
      valid_i = 1'b1;
      for (int i = 0; i < 65532; i++) begin data_i = i; tick(); end
      chk("cnt1_max", {16'h0, cnt1_o}, 32'hFFFF);
      tick();
      valid_i = 1'b0;
      chk("cnt1_sat", {16'h0, cnt1_o}, 32'hFFFF);
      chk("cnt0_kept", {16'h0, cnt0_o}, 5);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
